// File: rtl/lives_controller_pkg.sv
// Shared types for the life-count logic and the heart display.
package lives_pkg;
  localparam int LIVES_W = 2;

  typedef logic [LIVES_W-1:0] lives_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIVE,
    ST_RECOVER,
    ST_GAME_OVER
  } lives_state_t;

  // Increment that never exceeds the ceiling.
  function automatic lives_t lives_sat_inc(input lives_t v, input lives_t ceil);
    return (v < ceil) ? lives_t'(v + lives_t'(1)) : ceil;
  endfunction
endpackage

// File: rtl/lives_controller_if.sv
// Event pulses in from collision/score/video logic, life status out to display.
interface lives_controller_if;
  import lives_pkg::*;

  logic   startOfFrame;
  logic   newGame;
  logic   playerHit;
  logic   extraLife;
  lives_t lives;
  logic   gameOver;
  logic   invulnerable;
  logic   playerVisible;
  logic   lifeLost;

  modport master (
    output startOfFrame, newGame, playerHit, extraLife,
    input  lives, gameOver, invulnerable, playerVisible, lifeLost
  );

  modport slave (
    input  startOfFrame, newGame, playerHit, extraLife,
    output lives, gameOver, invulnerable, playerVisible, lifeLost
  );
endinterface

// File: rtl/lives_controller_frame_timer.sv
// Loadable down-counter stepped by frame pulses; done fires on the 1->0 step.
module frame_timer #(
  parameter int W      = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  // done is combinational so the owner can act on the same edge the count expires
  assign done_o = en_i && (cnt_q == W'(1));

  // clear beats load beats count; count holds at 0 rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) begin
      if (done_o && RELOAD)          cnt_q <= load_val_i;
      else                           cnt_q <= cnt_q - W'(1);
    end
  end
endmodule

// File: rtl/lives_controller.sv
// Player life FSM: hit/extra-life bookkeeping, invulnerability window, blink, game over.
module lives_controller
  import lives_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic              clk,
  input  logic              resetN,
  lives_controller_if.slave bus
);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam lives_t LMAX = lives_t'(MAX_LIVES);

  lives_state_t state_q, state_d;
  lives_t       lives_q, lives_d;
  logic         gameover_q, invuln_q, vis_q, vis_d, lost_q;
  logic         hit_acc, tmr_clr, inv_en, inv_done, blink_done;

  assign inv_en = (state_q == ST_RECOVER) && bus.startOfFrame;

  frame_timer #(.W(IW), .RELOAD(1'b0)) u_invuln (
    .clk        (clk),
    .rst_n      (resetN),
    .clr_i      (tmr_clr),
    .load_i     (hit_acc),
    .load_val_i (IW'(INVULN_FRAMES)),
    .en_i       (inv_en),
    .done_o     (inv_done)
  );

  frame_timer #(.W(BW), .RELOAD(1'b1)) u_blink (
    .clk        (clk),
    .rst_n      (resetN),
    .clr_i      (tmr_clr),
    .load_i     (hit_acc),
    .load_val_i (BW'(BLINK_FRAMES)),
    .en_i       (inv_en),
    .done_o     (blink_done)
  );

  // Next state and lives: newGame > playerHit > extraLife; ignored hits do not block extraLife
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    hit_acc = 1'b0;
    tmr_clr = 1'b0;
    if (bus.newGame) begin
      state_d = ST_ALIVE;
      lives_d = LMAX;
      tmr_clr = 1'b1;
    end else if (bus.playerHit && state_q == ST_ALIVE) begin
      hit_acc = 1'b1;
      if (lives_q <= lives_t'(1)) begin
        state_d = ST_GAME_OVER;
        lives_d = '0;
      end else begin
        state_d = ST_RECOVER;
        lives_d = lives_q - lives_t'(1);
      end
    end else begin
      if (bus.extraLife && (state_q == ST_ALIVE || state_q == ST_RECOVER))
        lives_d = lives_sat_inc(lives_q, LMAX);
      if (state_q == ST_RECOVER && inv_done)
        state_d = ST_ALIVE;
    end
  end

  // Blink: forced on in ALIVE, restarts high on RECOVER entry, toggles per blink period
  always_comb begin
    vis_d = 1'b0;
    unique case (state_d)
      ST_ALIVE:   vis_d = 1'b1;
      ST_RECOVER: vis_d = (state_q != ST_RECOVER) ? 1'b1 :
                          (blink_done ? ~vis_q : vis_q);
      default:    vis_d = 1'b0;
    endcase
  end

  // State, lives and every output are registered off the next-state values
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      lives_q    <= '0;
      gameover_q <= 1'b0;
      invuln_q   <= 1'b0;
      vis_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      gameover_q <= (state_d == ST_GAME_OVER);
      invuln_q   <= (state_d == ST_RECOVER);
      vis_q      <= vis_d;
      lost_q     <= hit_acc;
    end
  end

  assign bus.lives         = lives_q;
  assign bus.gameOver      = gameover_q;
  assign bus.invulnerable  = invuln_q;
  assign bus.playerVisible = vis_q;
  assign bus.lifeLost      = lost_q;
endmodule

// File: tb/tb_lives_controller.sv
// Directed bench for lives_controller with MAX_LIVES=3, INVULN_FRAMES=120, BLINK_FRAMES=8.
module tb_lives_controller;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  lives_controller_if bus ();

  lives_controller #(.MAX_LIVES(3), .INVULN_FRAMES(120), .BLINK_FRAMES(8)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit ng, input bit hit, input bit xl, input bit sof);
    bus.newGame = ng; bus.playerHit = hit; bus.extraLife = xl; bus.startOfFrame = sof;
    cyc();
    bus.newGame = 0; bus.playerHit = 0; bus.extraLife = 0; bus.startOfFrame = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(0, 0, 0, 1);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.newGame = 0; bus.playerHit = 0; bus.extraLife = 0; bus.startOfFrame = 0;
    repeat (3) cyc();
    chk("rst_lives", bus.lives, 0);
    chk("rst_gameover", bus.gameOver, 0);
    chk("rst_invuln", bus.invulnerable, 0);
    chk("rst_visible", bus.playerVisible, 0);
    chk("rst_lifelost", bus.lifeLost, 0);
    resetN = 1'b1;
    cyc();

    // hit in IDLE is ignored
    pulse(0, 1, 0, 0);
    chk("idle_hit_lives", bus.lives, 0);
    chk("idle_hit_lost", bus.lifeLost, 0);

    pulse(1, 0, 0, 0);
    chk("ng_lives", bus.lives, 3);
    chk("ng_visible", bus.playerVisible, 1);
    chk("ng_gameover", bus.gameOver, 0);
    chk("ng_invuln", bus.invulnerable, 0);

    pulse(0, 0, 1, 0);
    chk("sat_alive_lives", bus.lives, 3);

    // hit + extraLife together: hit wins, extraLife dropped
    pulse(0, 1, 1, 0);
    chk("hitxl_lives", bus.lives, 2);
    chk("hitxl_lost", bus.lifeLost, 1);
    chk("hitxl_invuln", bus.invulnerable, 1);
    chk("hitxl_visible", bus.playerVisible, 1);
    cyc();
    chk("lost_one_pulse", bus.lifeLost, 0);

    // walk the window: blink toggles every 8 frames, hit ignored, extraLife applies
    for (int k = 1; k <= 119; k++) begin
      frames(1);
      if (k % 4 == 0) chk($sformatf("blink_f%0d", k), bus.playerVisible, ((k / 8) % 2 == 0) ? 1 : 0);
      if (k == 5) begin
        pulse(0, 1, 0, 0);
        chk("rec_hit_lives", bus.lives, 2);
        chk("rec_hit_lost", bus.lifeLost, 0);
      end
      if (k == 16) begin
        pulse(0, 0, 1, 0);
        chk("rec_xl_lives", bus.lives, 3);
        chk("rec_xl_invuln", bus.invulnerable, 1);
      end
    end
    chk("f119_invuln", bus.invulnerable, 1);

    // 120th frame ends the window; a hit in that same cycle is ignored
    pulse(0, 1, 0, 1);
    chk("f120_invuln", bus.invulnerable, 0);
    chk("f120_lost", bus.lifeLost, 0);
    chk("f120_lives", bus.lives, 3);
    chk("f120_visible", bus.playerVisible, 1);
    pulse(0, 1, 0, 0);
    chk("post_exit_hit_lives", bus.lives, 2);
    chk("post_exit_hit_lost", bus.lifeLost, 1);

    // newGame + hit together in RECOVER
    pulse(1, 1, 0, 0);
    chk("nghit_lives", bus.lives, 3);
    chk("nghit_lost", bus.lifeLost, 0);
    chk("nghit_invuln", bus.invulnerable, 0);
    chk("nghit_visible", bus.playerVisible, 1);

    // three spaced hits to game over
    pulse(0, 1, 0, 0);
    chk("fatal1_lives", bus.lives, 2);
    frames(120);
    chk("fatal1_window_end", bus.invulnerable, 0);
    pulse(0, 1, 0, 0);
    chk("fatal2_lives", bus.lives, 1);
    frames(120);
    pulse(0, 1, 0, 0);
    chk("fatal3_lives", bus.lives, 0);
    chk("fatal3_gameover", bus.gameOver, 1);
    chk("fatal3_lost", bus.lifeLost, 1);
    chk("fatal3_invuln", bus.invulnerable, 0);
    chk("fatal3_visible", bus.playerVisible, 0);
    pulse(0, 1, 0, 0);
    chk("go_hit_lives", bus.lives, 0);
    chk("go_hit_lost", bus.lifeLost, 0);
    pulse(0, 0, 1, 0);
    chk("go_xl_lives", bus.lives, 0);
    chk("go_hold", bus.gameOver, 1);

    // asynchronous reset in the middle of RECOVER
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    frames(3);
    chk("pre_rst_invuln", bus.invulnerable, 1);
    resetN = 1'b0;
    #1;
    chk("arst_lives", bus.lives, 0);
    chk("arst_invuln", bus.invulnerable, 0);
    chk("arst_visible", bus.playerVisible, 0);
    chk("arst_gameover", bus.gameOver, 0);
    cyc();
    resetN = 1'b1;
    cyc();
    pulse(0, 0, 1, 0);
    chk("idle_xl_lives", bus.lives, 0);
    pulse(0, 1, 0, 0);
    chk("idle2_hit_lost", bus.lifeLost, 0);
    pulse(1, 0, 0, 0);
    chk("restart_lives", bus.lives, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
